bridge_plant_model: RTL and testbench

Behavioural plant and environment emulator for the drawbridge controller. It consumes the controller outputs (motor MT, alarm AL, traffic light TFL) and produces the controller sensor inputs: deck limit switches H/L, boat sensor BS, and car entry/exit pulses CAIN/CAO. It is synthesizable, so a controller can be closed-loop tested on the board with buttons as car/boat requests, and in simulation.

---
 rtl/bridge_plant_model.sv | 181 ++++++++++++++++++
 tb/tb_bridge_plant_model.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_plant_model.sv
// Drawbridge plant/environment emulator: deck travel, limit switches, car and boat traffic.
// Optional `PLANT_FAULT_INJECT_EN adds FaultSel[1:0] to force the limit-switch outputs low.
module bridge_plant_model #(
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned CAR_TRANSIT  = 4,
  parameter int unsigned BOAT_PASS    = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       MT,
  input  logic       AL,
  input  logic       TFL,
  input  logic       CarReq,
  input  logic       BoatReq,
`ifdef PLANT_FAULT_INJECT_EN
  input  logic [1:0] FaultSel,
`endif
  output logic       H,
  output logic       L,
  output logic       BS,
  output logic       CAIN,
  output logic       CAO,
  output logic [3:0] Pos,
  output logic       Fault,
  output logic       AlarmSeen
);

  localparam logic [3:0] TOP       = 4'(TRAVEL_TICKS);
  localparam logic [3:0] TRANSIT   = 4'(CAR_TRANSIT);
  localparam logic [3:0] PASS_LAST = 4'(BOAT_PASS - 1);

  typedef enum logic [1:0] {
    C_IDLE,
    C_ENTER,
    C_CROSS,
    C_EXIT
  } car_state_t;

  logic [3:0] pos;
  logic [3:0] pos_nxt;
  logic       dir;
  logic       ndir;
  logic       at_top;
  logic       at_bot;
  logic       h_q;
  logic       l_q;
  logic       force_h;
  logic       force_l;
  car_state_t state;
  car_state_t state_nxt;
  logic       car_take;
  logic       car_pend;
  logic [3:0] car_tmr;
  logic       bs_q;
  logic [3:0] pass_cnt;
  logic       pass_done;
  logic       fault_q;
  logic       alarm_q;

  // One deck step with the result clamped to the travel range.
  function automatic logic [3:0] step_pos(input logic [3:0] p, input logic up);
    if (up) begin
      return (p >= TOP) ? TOP : p + 4'd1;
    end else begin
      return (p == 4'd0) ? 4'd0 : p - 4'd1;
    end
  endfunction

`ifdef PLANT_FAULT_INJECT_EN
  assign force_h = FaultSel[0];
  assign force_l = FaultSel[1];
`else
  assign force_h = 1'b0;
  assign force_l = 1'b0;
`endif

  assign at_top  = (pos == TOP);
  assign at_bot  = (pos == 4'd0);
  assign ndir    = at_bot ? 1'b1 : (at_top ? 1'b0 : dir);
  assign pos_nxt = MT ? step_pos(pos, ndir) : pos;

  // Deck stage: position, held direction, and registered limit switches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pos <= 4'd0;
      dir <= 1'b1;
      h_q <= 1'b0;
      l_q <= 1'b1;
    end else begin
      pos <= pos_nxt;
      if (MT) begin
        dir <= ndir;
      end
      h_q <= (pos_nxt == TOP) & ~force_h;
      l_q <= (pos_nxt == 4'd0) & ~force_l;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= C_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    car_take  = 1'b0;
    case (state)
      C_IDLE: begin
        if (car_pend && !TFL && at_bot) begin
          state_nxt = C_ENTER;
          car_take  = 1'b1;
        end
      end
      C_ENTER: state_nxt = C_CROSS;
      C_CROSS: begin
        if (car_tmr <= 4'd1) begin
          state_nxt = C_EXIT;
        end
      end
      C_EXIT:  state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Car stage: pending request, transit timer, and the deck-moved-under-car flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      car_pend <= 1'b0;
      car_tmr  <= 4'd0;
      fault_q  <= 1'b0;
    end else begin
      car_pend <= CarReq | (car_pend & ~car_take);
      if (state == C_ENTER) begin
        car_tmr <= TRANSIT;
      end else if (state == C_CROSS) begin
        car_tmr <= car_tmr - 4'd1;
      end
      if ((state != C_IDLE) && at_bot && MT) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign pass_done = bs_q && at_top && (pass_cnt == PASS_LAST);

  // Boat stage: waiting flag cleared after enough consecutive raised-deck cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bs_q     <= 1'b0;
      pass_cnt <= 4'd0;
      alarm_q  <= 1'b0;
    end else begin
      if (BoatReq) begin
        bs_q <= 1'b1;
      end else if (pass_done) begin
        bs_q <= 1'b0;
      end
      if (bs_q && at_top && !pass_done) begin
        pass_cnt <= pass_cnt + 4'd1;
      end else begin
        pass_cnt <= 4'd0;
      end
      if (AL) begin
        alarm_q <= 1'b1;
      end
    end
  end

  assign H         = h_q;
  assign L         = l_q;
  assign BS        = bs_q;
  assign CAIN      = (state == C_ENTER);
  assign CAO       = (state == C_EXIT);
  assign Pos       = pos;
  assign Fault     = fault_q;
  assign AlarmSeen = alarm_q;

endmodule

// File: tb/tb_bridge_plant_model.sv
// Bench for bridge_plant_model: directed plan steps then random traffic against a cycle model.
module tb_bridge_plant_model;

  localparam int TT = 4;
  localparam int CT = 3;
  localparam int BP = 2;

  logic       Clk;
  logic       Reset;
  logic       MT;
  logic       AL;
  logic       TFL;
  logic       CarReq;
  logic       BoatReq;
  logic [1:0] FaultSel;
  logic       H;
  logic       L;
  logic       BS;
  logic       CAIN;
  logic       CAO;
  logic [3:0] Pos;
  logic       Fault;
  logic       AlarmSeen;

  int checks = 0;
  int errors = 0;

  // Reference model: deck position/direction, car age on deck (-1 = none), boat run length.
  int m_pos;
  bit m_up;
  bit m_pend;
  int m_car;
  bit m_bs;
  int m_run;
  bit m_fault;
  bit m_alarm;
  bit m_fsh;
  bit m_fsl;

  bridge_plant_model #(
    .TRAVEL_TICKS(TT),
    .CAR_TRANSIT (CT),
    .BOAT_PASS   (BP)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .MT       (MT),
    .AL       (AL),
    .TFL      (TFL),
    .CarReq   (CarReq),
    .BoatReq  (BoatReq),
`ifdef PLANT_FAULT_INJECT_EN
    .FaultSel (FaultSel),
`endif
    .H        (H),
    .L        (L),
    .BS       (BS),
    .CAIN     (CAIN),
    .CAO      (CAO),
    .Pos      (Pos),
    .Fault    (Fault),
    .AlarmSeen(AlarmSeen)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_up = 1'b1; m_pend = 1'b0; m_car = -1;
    m_bs = 1'b0; m_run = 0; m_fault = 1'b0; m_alarm = 1'b0;
    m_fsh = 1'b0; m_fsl = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Pos"},  {4'b0, Pos},  8'(m_pos));
    chk({tag, ".H"},    {7'b0, H},    {7'b0, (m_pos == TT) && !m_fsh});
    chk({tag, ".L"},    {7'b0, L},    {7'b0, (m_pos == 0) && !m_fsl});
    chk({tag, ".BS"},   {7'b0, BS},   {7'b0, m_bs});
    chk({tag, ".CAIN"}, {7'b0, CAIN}, {7'b0, m_car == 0});
    chk({tag, ".CAO"},  {7'b0, CAO},  {7'b0, m_car == CT + 1});
    chk({tag, ".Fault"}, {7'b0, Fault}, {7'b0, m_fault});
    chk({tag, ".AlarmSeen"}, {7'b0, AlarmSeen}, {7'b0, m_alarm});
  endtask

  // Advance the model by one edge using the current inputs, clock the DUT, compare everything.
  task automatic step(input string tag);
    bit busy, top, clear, take;
    busy = (m_car >= 0);
    top  = (m_pos == TT);
    if (busy && m_pos == 0 && MT) m_fault = 1'b1;
    if (AL) m_alarm = 1'b1;
    clear = 1'b0;
    if (m_bs && top) begin
      m_run++;
      if (m_run == BP) begin
        clear = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (BoatReq) m_bs = 1'b1;
    else if (clear) m_bs = 1'b0;
    take = 1'b0;
    if (busy) begin
      m_car++;
      if (m_car > CT + 1) m_car = -1;
    end else if (m_pend && !TFL && m_pos == 0) begin
      m_car = 0;
      take = 1'b1;
    end
    m_pend = CarReq || (m_pend && !take);
    if (MT) begin
      if (m_pos == 0) m_up = 1'b1;
      else if (m_pos == TT) m_up = 1'b0;
      m_pos = m_up ? m_pos + 1 : m_pos - 1;
    end
`ifdef PLANT_FAULT_INJECT_EN
    m_fsh = FaultSel[0];
    m_fsl = FaultSel[1];
`endif
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic home();
    MT = 1'b1;
    for (int i = 0; i < 20 && m_pos != 0; i++) step("home");
    MT = 1'b0;
    chk("home_reached", {4'b0, Pos}, 8'd0);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    chk({tag, ".Pos"},   {4'b0, Pos}, 8'd0);
    chk({tag, ".L"},     {7'b0, L},   8'd1);
    chk({tag, ".H"},     {7'b0, H},   8'd0);
    chk({tag, ".BS"},    {7'b0, BS},  8'd0);
    chk({tag, ".Fault"}, {7'b0, Fault}, 8'd0);
    model_reset();
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; MT = 1'b0; AL = 1'b0; TFL = 1'b0;
    CarReq = 1'b0; BoatReq = 1'b0; FaultSel = 2'b00;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b1;
    step("idle");

    // Reset asynchronously while the deck is mid-travel with a boat waiting.
    MT = 1'b1; BoatReq = 1'b1;
    step("pre_reset1");
    BoatReq = 1'b0;
    step("pre_reset2");
    chk("pre_reset_pos", {4'b0, Pos}, 8'd2);
    MT = 1'b0;
    async_reset_check("async_reset");

    // Full travel up, then reversal at the high limit.
    MT = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step("raise");
      chk("raise_pos", {4'b0, Pos}, 8'(i));
      chk("raise_L", {7'b0, L}, 8'd0);
    end
    chk("top_H", {7'b0, H}, 8'd1);
    step("reverse");
    chk("reverse_pos", {4'b0, Pos}, 8'd3);
    chk("reverse_H", {7'b0, H}, 8'd0);
    home();

    // Mid-travel stall keeps position and direction.
    MT = 1'b1;
    step("stall_up1");
    step("stall_up2");
    MT = 1'b0;
    for (int i = 0; i < 5; i++) step("stall_hold");
    chk("stall_pos", {4'b0, Pos}, 8'd2);
    chk("stall_HL", {6'b0, H, L}, 8'd0);
    MT = 1'b1;
    step("stall_resume");
    chk("resume_pos", {4'b0, Pos}, 8'd3);
    home();

    // Car held by red light, then served; a second request queues behind it.
    TFL = 1'b1; CarReq = 1'b1;
    step("car_req_red");
    CarReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("car_red_wait");
      chk("car_red_noCAIN", {7'b0, CAIN}, 8'd0);
    end
    TFL = 1'b0;
    step("car_enter");
    chk("car_CAIN", {7'b0, CAIN}, 8'd1);
    step("car_cross1");
    CarReq = 1'b1;
    step("car_cross2");
    CarReq = 1'b0;
    step("car_cross3");
    step("car_exit");
    chk("car_CAO", {7'b0, CAO}, 8'd1);
    step("car2_idle");
    step("car2_enter");
    chk("car2_CAIN", {7'b0, CAIN}, 8'd1);
    for (int i = 0; i < 5; i++) step("car2_finish");

    // Boat: interrupted raise restarts the count, then a full pass clears BS.
    BoatReq = 1'b1;
    step("boat_req");
    BoatReq = 1'b0;
    chk("boat_BS", {7'b0, BS}, 8'd1);
    MT = 1'b1;
    for (int i = 0; i < 4; i++) step("boat_raise");
    step("boat_one_h");
    MT = 1'b0;
    step("boat_drop");
    chk("boat_interrupted_BS", {7'b0, BS}, 8'd1);
    home();
    MT = 1'b1;
    for (int i = 0; i < 4; i++) step("boat_raise2");
    MT = 1'b0;
    step("boat_h1");
    chk("boat_h1_BS", {7'b0, BS}, 8'd1);
    step("boat_h2");
    chk("boat_cleared_BS", {7'b0, BS}, 8'd0);
    AL = 1'b1;
    step("alarm");
    AL = 1'b0;
    chk("alarm_seen", {7'b0, AlarmSeen}, 8'd1);
    home();

    // Deck lifted with a car on it.
    CarReq = 1'b1;
    step("fault_req");
    CarReq = 1'b0;
    step("fault_enter");
    step("fault_cross");
    MT = 1'b1;
    step("fault_lift");
    MT = 1'b0;
    chk("fault_pos", {4'b0, Pos}, 8'd1);
    chk("fault_set", {7'b0, Fault}, 8'd1);
    for (int i = 0; i < 6; i++) step("fault_hold");
    home();
    chk("fault_sticky", {7'b0, Fault}, 8'd1);
    async_reset_check("fault_reset");

`ifdef PLANT_FAULT_INJECT_EN
    FaultSel = 2'b10;
    step("inject_L");
    chk("inject_L_low", {7'b0, L}, 8'd0);
    chk("inject_pos", {4'b0, Pos}, 8'd0);
    FaultSel = 2'b00;
    step("inject_off");
    chk("inject_L_back", {7'b0, L}, 8'd1);
`endif

    // Random closed-loop traffic.
    for (int i = 0; i < 400; i++) begin
      MT      = ($urandom_range(0, 9) < 5);
      TFL     = ($urandom_range(0, 3) == 0);
      CarReq  = ($urandom_range(0, 7) == 0);
      BoatReq = ($urandom_range(0, 9) == 0);
      AL      = ($urandom_range(0, 49) == 0);
`ifdef PLANT_FAULT_INJECT_EN
      FaultSel = 2'($urandom_range(0, 3));
`endif
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
